// File: rtl/uart_echo_tester.sv
// uart_echo_tester: UART echo-path self-test initiator (baud generator, TX, RX, control FSM).
// Sends bytes seed+n, waits for each echo and tallies pass, error and timeout results.

module uart_echo_baud #(
    parameter int LIMIT = 651,
    parameter int BITS  = 10
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);
    logic [BITS-1:0] cnt_q, cnt_d;
    assign tick_o = cnt_q == BITS'(LIMIT - 1);
    assign cnt_d  = tick_o ? '0 : cnt_q + BITS'(1);
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

module uart_echo_tx #(
    parameter int WORD_BITS    = 8,
    parameter int SAMPLE_TICKS = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 tick_i,
    input  logic                 start_i,
    input  logic [WORD_BITS-1:0] data_i,
    output logic                 tx_o,
    output logic                 done_o
);
    localparam int SB = $clog2(SAMPLE_TICKS + 1);
    localparam int NB = $clog2(WORD_BITS + 1);
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
    tx_state_e state_q, state_d;
    logic [SB-1:0] s_q, s_d;
    logic [NB-1:0] n_q, n_d;
    logic [WORD_BITS-1:0] b_q, b_d;
    logic tx_q, tx_d, last_tick;
    assign tx_o = tx_q;
    assign last_tick = tick_i && s_q == SB'(SAMPLE_TICKS - 1);
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state_q <= T_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    always_comb begin
        state_d = state_q;
        s_d     = tick_i ? s_q + SB'(1) : s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_o  = 1'b0;
        unique case (state_q)
            T_IDLE: begin
                s_d = '0;
                if (start_i) begin
                    state_d = T_START;
                    b_d     = data_i;
                end
            end
            T_START: if (last_tick) begin
                state_d = T_DATA;
                s_d     = '0;
                n_d     = '0;
            end
            T_DATA: if (last_tick) begin
                s_d     = '0;
                b_d     = b_q >> 1;
                n_d     = n_q + NB'(1);
                state_d = (n_q == NB'(WORD_BITS - 1)) ? T_STOP : T_DATA;
            end
            T_STOP: if (last_tick) begin
                state_d = T_IDLE;
                done_o  = 1'b1;
            end
            default: state_d = T_IDLE;
        endcase
        // Line level follows the next state so each bit is held for whole tick periods.
        tx_d = (state_d == T_START) ? 1'b0 : (state_d == T_DATA) ? b_d[0] : 1'b1;
    end
endmodule

module uart_echo_rx #(
    parameter int WORD_BITS    = 8,
    parameter int SAMPLE_TICKS = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 tick_i,
    input  logic                 rx_i,
    output logic [WORD_BITS-1:0] data_o,
    output logic                 done_o
);
    localparam int SB = $clog2(SAMPLE_TICKS + 1);
    localparam int NB = $clog2(WORD_BITS + 1);
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    rx_state_e state_q, state_d;
    logic [SB-1:0] s_q, s_d;
    logic [NB-1:0] n_q, n_d;
    logic [WORD_BITS-1:0] b_q, b_d;
    logic [1:0] sync_q;
    logic rx_s, bit_end;
    assign rx_s    = sync_q[1];
    assign data_o  = b_q;
    assign bit_end = tick_i && s_q == SB'(SAMPLE_TICKS - 1);
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state_q <= R_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            sync_q  <= {sync_q[0], rx_i};
        end
    always_comb begin
        state_d = state_q;
        s_d     = tick_i ? s_q + SB'(1) : s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_o  = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                s_d = '0;
                if (!rx_s) state_d = R_START;
            end
            // Half a bit into the start bit, then sample every full bit at mid-bit.
            R_START: if (tick_i && s_q == SB'(SAMPLE_TICKS / 2 - 1)) begin
                state_d = R_DATA;
                s_d     = '0;
                n_d     = '0;
            end
            R_DATA: if (bit_end) begin
                s_d     = '0;
                b_d     = {rx_s, b_q[WORD_BITS-1:1]};
                n_d     = n_q + NB'(1);
                state_d = (n_q == NB'(WORD_BITS - 1)) ? R_STOP : R_DATA;
            end
            R_STOP: if (bit_end) begin
                state_d = R_IDLE;
                done_o  = 1'b1;
            end
            default: state_d = R_IDLE;
        endcase
    end
endmodule

module uart_echo_tester #(
    parameter int WORD_BITS     = 8,
    parameter int SAMPLE_TICKS  = 16,
    parameter int BAUD_LIMIT    = 651,
    parameter int BAUD_BITS     = 10,
    parameter int TIMEOUT_TICKS = 4096,
    parameter int TIMEOUT_BITS  = 13,
    parameter int COUNT_BITS    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [COUNT_BITS-1:0] count_i,
    input  logic [WORD_BITS-1:0]  seed_i,
    input  logic                  rx_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [COUNT_BITS-1:0] sent_o,
    output logic [COUNT_BITS-1:0] pass_o,
    output logic [COUNT_BITS-1:0] error_o,
    output logic [COUNT_BITS-1:0] timeout_o,
    output logic [WORD_BITS-1:0]  last_tx_o,
    output logic [WORD_BITS-1:0]  last_rx_o,
    output logic                  baud_tick_o
);
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_ECHO, CHECK, NEXT, FINISH} state_e;
    state_e state_q, state_d;
    logic [COUNT_BITS-1:0] count_q, count_d, sent_q, sent_d, pass_q, pass_d;
    logic [COUNT_BITS-1:0] error_q, error_d, timeout_q, timeout_d;
    logic [WORD_BITS-1:0] byte_q, byte_d, last_tx_q, last_tx_d, last_rx_q, last_rx_d, rx_data;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic echo_q, echo_d, done_q, done_d, tick, tx_start, tx_done, rx_done;

    uart_echo_baud #(.LIMIT(BAUD_LIMIT), .BITS(BAUD_BITS)) u_baud (
        .clk_i(clk_i), .reset_i(reset_i), .tick_o(tick)
    );
    uart_echo_tx #(.WORD_BITS(WORD_BITS), .SAMPLE_TICKS(SAMPLE_TICKS)) u_tx (
        .clk_i(clk_i), .reset_i(reset_i), .tick_i(tick), .start_i(tx_start),
        .data_i(byte_q), .tx_o(tx_o), .done_o(tx_done)
    );
    uart_echo_rx #(.WORD_BITS(WORD_BITS), .SAMPLE_TICKS(SAMPLE_TICKS)) u_rx (
        .clk_i(clk_i), .reset_i(reset_i), .tick_i(tick), .rx_i(rx_i),
        .data_o(rx_data), .done_o(rx_done)
    );

    assign busy_o      = state_q != IDLE;
    assign done_o      = done_q;
    assign sent_o      = sent_q;
    assign pass_o      = pass_q;
    assign error_o     = error_q;
    assign timeout_o   = timeout_q;
    assign last_tx_o   = last_tx_q;
    assign last_rx_o   = last_rx_q;
    assign baud_tick_o = tick;

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            sent_q    <= '0;
            pass_q    <= '0;
            error_q   <= '0;
            timeout_q <= '0;
            byte_q    <= '0;
            last_tx_q <= '0;
            last_rx_q <= '0;
            tmo_q     <= '0;
            echo_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            sent_q    <= sent_d;
            pass_q    <= pass_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            byte_q    <= byte_d;
            last_tx_q <= last_tx_d;
            last_rx_q <= last_rx_d;
            tmo_q     <= tmo_d;
            echo_q    <= echo_d;
            done_q    <= done_d;
        end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        sent_d    = sent_q;
        pass_d    = pass_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        byte_d    = byte_q;
        last_tx_d = last_tx_q;
        last_rx_d = last_rx_q;
        tmo_d     = tmo_q;
        echo_d    = echo_q;
        done_d    = 1'b0;
        tx_start  = 1'b0;
        // Echoes are captured in every active state so one landing during SEND is kept.
        if (rx_done && state_q != IDLE && state_q != FINISH) begin
            echo_d    = 1'b1;
            last_rx_d = rx_data;
        end
        unique case (state_q)
            IDLE: if (start_i) begin
                count_d   = count_i;
                byte_d    = seed_i;
                sent_d    = '0;
                pass_d    = '0;
                error_d   = '0;
                timeout_d = '0;
                echo_d    = 1'b0;
                state_d   = (count_i == '0) ? FINISH : LOAD;
            end
            LOAD: begin
                tx_start  = 1'b1;
                last_tx_d = byte_q;
                state_d   = SEND;
            end
            SEND: if (tx_done) begin
                sent_d  = sent_q + COUNT_BITS'(1);
                tmo_d   = '0;
                state_d = WAIT_ECHO;
            end
            WAIT_ECHO:
                if (echo_q) state_d = CHECK;
                else if (tick && tmo_q == TIMEOUT_BITS'(TIMEOUT_TICKS - 1)) begin
                    timeout_d = timeout_q + COUNT_BITS'(1);
                    state_d   = NEXT;
                end else if (tick) tmo_d = tmo_q + TIMEOUT_BITS'(1);
            CHECK: begin
                pass_d  = (last_rx_q == last_tx_q) ? pass_q + COUNT_BITS'(1) : pass_q;
                error_d = (last_rx_q != last_tx_q) ? error_q + COUNT_BITS'(1) : error_q;
                echo_d  = rx_done;
                state_d = NEXT;
            end
            NEXT:
                if (sent_q == count_q) state_d = FINISH;
                else begin
                    byte_d  = byte_q + WORD_BITS'(1);
                    state_d = LOAD;
                end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/uart_echo_tester.md
# uart_echo_tester

Link self-test initiator: the transmitting end that drives the board's UART echo path. It sends a programmable burst of incrementing bytes on `tx_o`, waits for each byte to come back on `rx_i`, and compares the echo against what was sent. It accumulates pass, mismatch and timeout counts for bring-up and regression of the echo datapath.

Internally it instantiates the codebase's baud generator, UART transmitter and UART receiver, all sharing one baud tick.

## Interface
Parameters:
- WORD_BITS, 8, data word width.
- SAMPLE_TICKS, 16, oversampling/stop ticks, passed to TX and RX.
- BAUD_LIMIT, 651, baud generator count limit.
- BAUD_BITS, 10, baud counter width.
- TIMEOUT_TICKS, 4096, baud ticks to wait for an echo before declaring a timeout.
- TIMEOUT_BITS, 13, timeout counter width; must satisfy 2^TIMEOUT_BITS > TIMEOUT_TICKS.
- COUNT_BITS, 16, width of byte count and result counters.

Ports (reset reset_i, asynchronous, active-high; clock clk_i):
- clk_i  in  1  clock
- reset_i  in  1  async active-high reset
- start_i  in  1  begin a run; sampled only in IDLE
- count_i  in  COUNT_BITS  number of bytes to send; latched on start
- seed_i  in  WORD_BITS  first byte value; latched on start
- rx_i  in  1  serial echo input
- tx_o  out  1  serial output, idle high
- busy_o  out  1  high from the cycle after start acceptance until done_o
- done_o  out  1  one-cycle pulse at end of run
- sent_o  out  COUNT_BITS  bytes transmitted this run
- pass_o  out  COUNT_BITS  echoes equal to the sent byte
- error_o  out  COUNT_BITS  echoes differing from the sent byte
- timeout_o  out  COUNT_BITS  bytes with no echo within TIMEOUT_TICKS
- last_tx_o  out  WORD_BITS  most recent byte sent
- last_rx_o  out  WORD_BITS  most recent echo received
- baud_tick_o  out  1  baud/oversample tick

## Operation
- Byte n (n = 0..count-1) is seed + n, modulo 2^WORD_BITS, so 0xFF wraps to 0x00.
- FSM states: IDLE, LOAD, SEND, WAIT_ECHO, CHECK, NEXT, FINISH.
- IDLE:
  - On start_i = 1: latch count_i and seed_i, clear all result counters and the echo flag.
  - If the latched count is 0, go to FINISH; otherwise go to LOAD.
- LOAD: drive transmitter start with the current byte for exactly one cycle, set last_tx_o, then go to SEND.
- SEND: wait for the transmitter's done, then increment sent_o, clear the timeout counter and go to WAIT_ECHO.
- Echo flag:
  - A receiver done in any state except IDLE/FINISH sets the echo flag and stores the received word in last_rx_o.
  - This means an echo arriving during SEND is not lost.
  - A second echo before CHECK overwrites the stored word; it is still only one event.
- WAIT_ECHO:
  - If the echo flag is set, go to CHECK.
  - Otherwise count baud ticks; when the count reaches TIMEOUT_TICKS, increment timeout_o and go to NEXT.
- CHECK: if last_rx_o equals last_tx_o, increment pass_o; otherwise increment error_o. Clear the echo flag and go to NEXT.
- NEXT: if sent_o equals the latched count, go to FINISH; otherwise advance the byte and go to LOAD.
- FINISH: pulse done_o and return to IDLE.
- Counters and last_* outputs hold their values after done until the next start.
- start_i while busy is ignored.
- Invariant at done: pass_o + error_o + timeout_o = sent_o = latched count.

## Timing
- Reset values:
  - All counters, last_tx_o and last_rx_o are 0.
  - busy_o and done_o are 0.
  - tx_o is 1.
  - FSM is in IDLE.
  - Baud counter is 0.
- Reset mid-run aborts immediately to these values. tx_o returns high asynchronously with reset. No partial byte resumes.
- start_i is sampled on a rising edge. Transmitter start is asserted on the following cycle (LOAD).
- With count = 0, done_o pulses exactly 2 cycles after the start edge (IDLE→FINISH→pulse).
- done_o is high for exactly one clk_i cycle, and busy_o falls in the same cycle.
- Echo compare latency: CHECK executes 1 cycle after the echo flag is seen in WAIT_ECHO. Counters update on the edge leaving CHECK or WAIT_ECHO.
- Timeout measures baud ticks only, starting from entry into WAIT_ECHO. Byte period is 10 bits × SAMPLE_TICKS baud ticks.

## Test plan
Simulation uses BAUD_LIMIT = 4 and TIMEOUT_TICKS = 400 unless stated.

- **Loopback:** tx_o tied to rx_i, seed = 0x41, count = 4 → done_o once; sent = pass = 4, error = timeout = 0, last_tx_o = last_rx_o = 0x44.
- **No echo:** rx_i held at 1, count = 2, TIMEOUT_TICKS = 64 → timeout = 2, pass = error = 0, sent = 2.
- **Corrupt echo:** a bench UART model echoes each byte but XORs the second byte with 0x01; seed = 0x10, count = 3 → pass = 2, error = 1, timeout = 0.
- **Wrap:** seed = 0xFE, count = 3, loopback → serial bytes observed 0xFE, 0xFF, 0x00; pass = 3.
- **Zero count and busy start:** count = 0 → done_o 2 cycles after start, all counters 0. Then start a run with count = 2 and re-pulse start_i mid-run → ignored, sent = 2.
- **Reset mid-run:** assert reset_i during the second byte → all outputs at reset values, tx_o = 1. A subsequent start with count = 1 in loopback gives pass = 1.
